// File: rtl/ucode_pkg.sv
// ucode_pkg: shared sequencer types and microword layout constants
package ucode_pkg;
  localparam int SEQ_W = 3;
  typedef enum logic [SEQ_W-1:0] {SEQ_NEXT, SEQ_JUMP, SEQ_BR, SEQ_BRN, SEQ_END, SEQ_IRET} seq_e;
  typedef enum logic {IDLE, EXEC} state_e;
endpackage

// File: rtl/ucode_store.sv
// ucode_store: generic RAM with asynchronous read and synchronous write
module ucode_store #(
  parameter int W = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: microcoded control unit with writable microstore, dispatch table and interrupt entry
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int OP_W = 5,
  parameter int FLAG_W = 4,
  parameter int UADDR_W = 6,
  parameter int CTRL_W = 12,
  parameter logic [UADDR_W-1:0] IRQ_VEC = 6'h30,
  localparam int FSEL_W = $clog2(FLAG_W),
  localparam int UWORD_W = CTRL_W + SEQ_W + FSEL_W + UADDR_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [OP_W-1:0]    OPCode,
  input  logic [FLAG_W-1:0]  FLAG,
  input  logic               stall,
  input  logic               interrupt,
  output logic               irq_ack,
  output logic               in_irq,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               ctrl_valid,
  output logic [UADDR_W-1:0] upc,
  output logic               ucode_err,
  input  logic               ld_en,
  input  logic               ld_sel,
  input  logic [UADDR_W-1:0] ld_addr,
  input  logic [UWORD_W-1:0] ld_data
);
  localparam int SEQ_LSB = CTRL_W;
  localparam int FSEL_LSB = SEQ_LSB + SEQ_W;
  localparam int TGT_LSB = FSEL_LSB + FSEL_W;
  state_e state, state_n;
  logic [UADDR_W-1:0] upc_n, dsp, tgt;
  logic [UWORD_W-1:0] uw;
  logic [SEQ_W-1:0] seq;
  logic [FSEL_W-1:0] fsel;
  logic idle, flag, take, fall, in_irq_n, err_n;
  assign idle = state == IDLE;
  ucode_store #(.W(UWORD_W), .AW(UADDR_W)) u_ustore (
    .clk(CLK), .we(ld_en & ~ld_sel & idle), .waddr(ld_addr), .wdata(ld_data),
    .raddr(upc), .rdata(uw)
  );
  ucode_store #(.W(UADDR_W), .AW(OP_W)) u_dispatch (
    .clk(CLK), .we(ld_en & ld_sel & idle), .waddr(ld_addr[OP_W-1:0]),
    .wdata(ld_data[UADDR_W-1:0]), .raddr(OPCode), .rdata(dsp)
  );
  assign seq = uw[SEQ_LSB +: SEQ_W];
  assign fsel = uw[FSEL_LSB +: FSEL_W];
  assign tgt = uw[TGT_LSB +: UADDR_W];
  assign flag = FLAG[fsel];
  assign take = seq == SEQ_JUMP || (seq == SEQ_BR && flag) || (seq == SEQ_BRN && !flag);
  assign fall = seq == SEQ_NEXT || seq == SEQ_BR || seq == SEQ_BRN;
  always_comb begin
    state_n = state;
    upc_n = upc;
    in_irq_n = in_irq;
    err_n = ucode_err;
    op_ready = 1'b0;
    irq_ack = 1'b0;
    ctrl = '0;
    ctrl_valid = 1'b0;
    if (idle) begin
      irq_ack = interrupt & ~in_irq;
      op_ready = ~irq_ack;
      upc_n = irq_ack ? IRQ_VEC : op_valid ? dsp : upc;
      state_n = (irq_ack | op_valid) ? EXEC : IDLE;
      in_irq_n = in_irq | irq_ack;
    end else begin
      ctrl = uw[CTRL_W-1:0];
      ctrl_valid = ~stall;
      if (!stall) begin
        upc_n = take ? tgt : fall ? upc + UADDR_W'(1) : upc;
        state_n = (take | fall) ? EXEC : IDLE;
        in_irq_n = seq == SEQ_IRET ? 1'b0 : in_irq;
        err_n = ucode_err | (seq > SEQ_IRET);
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      upc <= '0;
      in_irq <= 1'b0;
      ucode_err <= 1'b0;
    end else begin
      state <= state_n;
      upc <= upc_n;
      in_irq <= in_irq_n;
      ucode_err <= err_n;
    end
  end
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: scenario tasks plus randomized programs checked against a trace-level model
module tb_ucode_sequencer;
  logic CLK = 0, RST, op_valid, op_ready, stall, interrupt, irq_ack, in_irq, ctrl_valid, ucode_err;
  logic ld_en, ld_sel;
  logic [4:0] OPCode;
  logic [3:0] FLAG;
  logic [11:0] ctrl;
  logic [5:0] upc, ld_addr;
  logic [22:0] ld_data;
  int total = 0, bad = 0;
  logic [22:0] um [64];
  logic [5:0] dm [32];
  logic [11:0] exp_q [$];
  logic exp_err = 0, exp_irq = 0;

  ucode_sequencer dut (
    .CLK(CLK), .RST(RST), .op_valid(op_valid), .op_ready(op_ready), .OPCode(OPCode), .FLAG(FLAG),
    .stall(stall), .interrupt(interrupt), .irq_ack(irq_ack), .in_irq(in_irq), .ctrl(ctrl),
    .ctrl_valid(ctrl_valid), .upc(upc), .ucode_err(ucode_err), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 CLK = ~CLK;

  function automatic logic [22:0] mkw(input int t, input int fs, input int s, input int c);
    return {6'(t), 2'(fs), 3'(s), 12'(c)};
  endfunction

  // Walks the microprogram by the sequencing rules and records the ctrl words it emits.
  task automatic predict(input int start, input logic [3:0] fl);
    int pc, s, fs, t;
    logic [22:0] w;
    exp_q.delete();
    pc = start;
    for (int n = 0; n < 64; n++) begin
      w = um[pc];
      exp_q.push_back(w[11:0]);
      s = int'(w[14:12]);
      fs = int'(w[16:15]);
      t = int'(w[22:17]);
      if (s >= 4) begin
        if (s >= 6) exp_err = 1;
        if (s == 5) exp_irq = 0;
        break;
      end
      pc = (s == 1 || (s == 2 && fl[fs]) || (s == 3 && !fl[fs])) ? t : (pc + 1) % 64;
    end
  endtask

  task automatic load(input logic sel, input int a, input logic [22:0] d);
    @(negedge CLK);
    ld_en = 1; ld_sel = sel; ld_addr = 6'(a); ld_data = d;
    @(posedge CLK);
    #1 ld_en = 0;
    if (sel) dm[a % 32] = d[5:0];
    else um[a % 64] = d;
  endtask

  task automatic run_op(input int op, input logic [3:0] fl, input bit rs);
    int ns;
    predict(int'(dm[op]), fl);
    @(negedge CLK);
    op_valid = 1; OPCode = 5'(op); FLAG = fl;
    #1 total++;
    if (op_ready !== 1 || irq_ack !== 0) begin
      bad++; $display("FAIL accept op%0d: op_ready=%b irq_ack=%b want 1 0", op, op_ready, irq_ack);
    end
    foreach (exp_q[k]) begin
      @(negedge CLK);
      op_valid = 0;
      ns = (rs && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      repeat (ns) begin
        stall = 1;
        #1 total++;
        if (ctrl !== exp_q[k] || ctrl_valid !== 0 || op_ready !== 0) begin
          bad++; $display("FAIL stall op%0d w%0d: ctrl=%h valid=%b want %h 0", op, k, ctrl, ctrl_valid, exp_q[k]);
        end
        @(negedge CLK);
      end
      stall = 0;
      #1 total++;
      if (ctrl !== exp_q[k] || ctrl_valid !== 1) begin
        bad++; $display("FAIL word op%0d w%0d: ctrl=%h valid=%b want %h 1", op, k, ctrl, ctrl_valid, exp_q[k]);
      end
    end
    @(negedge CLK);
    #1 total++;
    if (op_ready !== 1 || ctrl_valid !== 0 || ctrl !== 0 || ucode_err !== exp_err || in_irq !== exp_irq) begin
      bad++;
      $display("FAIL done op%0d: ready=%b valid=%b ctrl=%h err=%b irq=%b want 1 0 000 %b %b",
               op, op_ready, ctrl_valid, ctrl, ucode_err, in_irq, exp_err, exp_irq);
    end
  endtask

  task automatic test_reset;
    RST = 1;
    repeat (2) @(negedge CLK);
    RST = 0;
    #1 total++;
    if (op_ready !== 1 || ctrl !== 0 || ctrl_valid !== 0 || upc !== 0 || in_irq !== 0 || irq_ack !== 0 || ucode_err !== 0) begin
      bad++;
      $display("FAIL reset: ready=%b ctrl=%h valid=%b upc=%h irq=%b ack=%b err=%b want 1 000 0 00 0 0 0",
               op_ready, ctrl, ctrl_valid, upc, in_irq, irq_ack, ucode_err);
    end
  endtask

  task automatic test_single_op;
    load(0, 0, mkw(0, 0, 4, 'h940));
    load(1, 1, 23'd0);
    run_op(1, 4'b0000, 0);
  endtask

  task automatic test_branch;
    load(0, 4, mkw(8, 2, 2, 'h910));
    load(0, 5, mkw(0, 0, 4, 'h930));
    load(0, 8, mkw(0, 0, 4, 'h400));
    load(1, 3, 23'd4);
    run_op(3, 4'b0100, 0);
    run_op(3, 4'b0000, 0);
    run_op(3, 4'b1011, 0);
  endtask

  task automatic test_interrupt;
    load(0, 'h30, mkw(0, 0, 5, 'h9c0));
    @(negedge CLK);
    interrupt = 1; op_valid = 1; OPCode = 1;
    #1 total++;
    if (op_ready !== 0 || irq_ack !== 1) begin
      bad++; $display("FAIL irq entry: ready=%b ack=%b want 0 1", op_ready, irq_ack);
    end
    @(negedge CLK);
    #1 total++;
    if (ctrl !== 'h9c0 || ctrl_valid !== 1 || in_irq !== 1 || irq_ack !== 0 || op_ready !== 0) begin
      bad++; $display("FAIL irq body: ctrl=%h valid=%b irq=%b ack=%b ready=%b want 9c0 1 1 0 0",
                      ctrl, ctrl_valid, in_irq, irq_ack, op_ready);
    end
    @(negedge CLK);
    #1 total++;
    if (irq_ack !== 1 || in_irq !== 0 || op_ready !== 0) begin
      bad++; $display("FAIL irq reentry: ack=%b irq=%b ready=%b want 1 0 0", irq_ack, in_irq, op_ready);
    end
    @(negedge CLK);
    interrupt = 0; op_valid = 0;
    #1 total++;
    if (ctrl !== 'h9c0 || in_irq !== 1) begin
      bad++; $display("FAIL irq body2: ctrl=%h irq=%b want 9c0 1", ctrl, in_irq);
    end
    @(negedge CLK);
    #1 total++;
    if (op_ready !== 1 || irq_ack !== 0 || in_irq !== 0) begin
      bad++; $display("FAIL irq exit: ready=%b ack=%b irq=%b want 1 0 0", op_ready, irq_ack, in_irq);
    end
    // Handler ending in END leaves in_irq set, so the held request must stay blocked.
    load(0, 'h30, mkw(0, 0, 4, 'h9c0));
    @(negedge CLK);
    interrupt = 1;
    #1 total++;
    if (irq_ack !== 1) begin
      bad++; $display("FAIL irq entry2: ack=%b want 1", irq_ack);
    end
    @(negedge CLK);
    #1 total++;
    if (ctrl !== 'h9c0 || in_irq !== 1) begin
      bad++; $display("FAIL irq body3: ctrl=%h irq=%b want 9c0 1", ctrl, in_irq);
    end
    @(negedge CLK);
    op_valid = 1; OPCode = 1;
    #1 total++;
    if (irq_ack !== 0 || op_ready !== 1 || in_irq !== 1) begin
      bad++; $display("FAIL nested block: ack=%b ready=%b irq=%b want 0 1 1", irq_ack, op_ready, in_irq);
    end
    @(negedge CLK);
    op_valid = 0; interrupt = 0;
    #1 total++;
    if (ctrl !== um[dm[1]][11:0] || ctrl_valid !== 1) begin
      bad++; $display("FAIL nested op: ctrl=%h valid=%b want %h 1", ctrl, ctrl_valid, um[dm[1]][11:0]);
    end
    load(0, 'h30, mkw(0, 0, 5, 'h9c1));
    load(1, 4, 23'h30);
    exp_irq = 1;
    run_op(4, 4'b0000, 0);
  endtask

  task automatic test_stall_wrap;
    load(0, 63, mkw(0, 0, 0, 'h801));
    load(0, 0, mkw(0, 0, 4, 'h821));
    load(1, 2, 23'd63);
    @(negedge CLK);
    op_valid = 1; OPCode = 2;
    @(negedge CLK);
    op_valid = 0;
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      #1 total++;
      if (ctrl !== 'h801 || ctrl_valid !== 0 || upc !== 63) begin
        bad++; $display("FAIL stall%0d: ctrl=%h valid=%b upc=%0d want 801 0 63", i, ctrl, ctrl_valid, upc);
      end
      @(negedge CLK);
    end
    stall = 0;
    #1 total++;
    if (ctrl !== 'h801 || ctrl_valid !== 1) begin
      bad++; $display("FAIL release: ctrl=%h valid=%b want 801 1", ctrl, ctrl_valid);
    end
    @(negedge CLK);
    #1 total++;
    if (ctrl !== 'h821 || upc !== 0 || ctrl_valid !== 1) begin
      bad++; $display("FAIL wrap: ctrl=%h upc=%0d valid=%b want 821 0 1", ctrl, upc, ctrl_valid);
    end
    @(negedge CLK);
    #1 total++;
    if (op_ready !== 1) begin
      bad++; $display("FAIL wrap done: ready=%b want 1", op_ready);
    end
  endtask

  task automatic test_error_reset;
    load(0, 20, mkw(0, 0, 6, 'h777));
    load(1, 6, 23'd20);
    run_op(6, 4'b0000, 0);
    run_op(3, 4'b0100, 0);
    load(0, 10, mkw(0, 0, 0, 'hA01));
    load(0, 11, mkw(0, 0, 0, 'hA02));
    load(0, 12, mkw(0, 0, 4, 'hA03));
    load(1, 5, 23'd10);
    @(negedge CLK);
    op_valid = 1; OPCode = 5;
    @(negedge CLK);
    op_valid = 0;
    ld_en = 1; ld_sel = 0; ld_addr = 12; ld_data = mkw(0, 0, 4, 'hBAD);
    #1 total++;
    if (ctrl !== 'hA01) begin
      bad++; $display("FAIL mid w0: ctrl=%h want a01", ctrl);
    end
    @(negedge CLK);
    ld_en = 0; RST = 1;
    #1 total++;
    if (ctrl !== 'hA02) begin
      bad++; $display("FAIL mid w1: ctrl=%h want a02", ctrl);
    end
    @(negedge CLK);
    RST = 0;
    #1 total++;
    if (op_ready !== 1 || ctrl !== 0 || ctrl_valid !== 0 || upc !== 0 || in_irq !== 0 || ucode_err !== 0) begin
      bad++;
      $display("FAIL mid reset: ready=%b ctrl=%h valid=%b upc=%h irq=%b err=%b want 1 000 0 00 0 0",
               op_ready, ctrl, ctrl_valid, upc, in_irq, ucode_err);
    end
    exp_err = 0;
    run_op(5, 4'b0000, 0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 20; it++) begin
      int b, op;
      b = int'($urandom_range(0, 40));
      op = int'($urandom_range(8, 31));
      for (int i = 0; i < 5; i++) begin
        int s;
        s = int'($urandom_range(0, 3));
        load(0, b + i, mkw(int'($urandom_range(b + i + 1, b + 5)), int'($urandom_range(0, 3)), s,
                           int'($urandom_range(0, 4095))));
      end
      load(0, b + 5, mkw(0, 0, 4, int'($urandom_range(0, 4095))));
      load(1, op, 23'(b));
      run_op(op, 4'($urandom_range(0, 15)), 1);
    end
  endtask

  initial begin
    RST = 1; op_valid = 0; OPCode = 0; FLAG = 0; stall = 0; interrupt = 0;
    ld_en = 0; ld_sel = 0; ld_addr = 0; ld_data = 0;
    test_reset();
    test_single_op();
    test_branch();
    test_interrupt();
    test_stall_wrap();
    test_error_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
